uart_bus_bridge: RTL

- Bus initiator driven by a host over UART: the host-side counterpart of the memory-mapped UART peripheral, which is a bus responder.
- Decodes a byte-stream command protocol from the UART core's receive strobe interface.
- Issues single 32-bit read/write transactions on the internal CPU bus.
- Returns a response byte stream through the UART core's transmit interface.
- Used for program loading and debug peek/poke without the CPU.

---
 rtl/uart_bus_bridge_pkg.sv | 32 +++
 rtl/uart_bridge_txseq.sv | 73 +++++++
 rtl/uart_bus_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bus_bridge_pkg
//  Description : Shared types and constants for the UART-to-bus bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_bus_bridge_pkg;

    // Frame decoder states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        TX   = 3'd4
    } state_e;

    localparam logic [7:0] OP_WRITE = 8'h57;   // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;   // 'R'
    localparam logic [7:0] RSP_ACK  = 8'h4B;   // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h3F;   // '?'

    // Address and data fields are both this many bytes on the wire
    localparam int FRAME_BYTES = 4;

    // Widen a single response byte into the word fed to the transmit sequencer
    function automatic logic [31:0] byte_word(input logic [7:0] b);
        return {24'h0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bridge_txseq.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bridge_txseq
//  Description : Sends 1 or 4 bytes (LSB first) of a loaded word through the
//                UART transmit strobe handshake and flags the final byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bridge_txseq (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,        // start a new response
    input  logic [31:0] word_i,        // response bytes, byte 0 sent first
    input  logic        four_i,        // 1 = send 4 bytes, 0 = send 1 byte
    output logic        tx_write_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_finished_i,
    output logic        done_o         // pulses with the last tx_finished
);

    logic [31:0] sreg_q,   sreg_d;
    logic [2:0]  left_q,   left_d;
    logic        active_q, active_d;
    logic        write_q,  write_d;

    // A finish strobe only counts once our own write strobe has gone out
    logic w_byte_done;
    assign w_byte_done = active_q && !write_q && tx_finished_i;

    assign tx_write_o = write_q;
    assign tx_data_o  = sreg_q[7:0];
    assign done_o     = w_byte_done && (left_q == 3'd1);

    // Next-state: load, then advance one byte per tx_finished
    always_comb begin
        sreg_d   = sreg_q;
        left_d   = left_q;
        active_d = active_q;
        write_d  = 1'b0;
        if (load_i) begin
            sreg_d   = word_i;
            left_d   = four_i ? 3'd4 : 3'd1;
            active_d = 1'b1;
            write_d  = 1'b1;
        end else if (w_byte_done) begin
            if (left_q == 3'd1) begin
                // Keep the last byte on tx_data; nothing left to send
                left_d   = 3'd0;
                active_d = 1'b0;
            end else begin
                sreg_d  = {8'h00, sreg_q[31:8]};
                left_d  = left_q - 3'd1;
                write_d = 1'b1;
            end
        end
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q   <= '0;
            left_q   <= '0;
            active_q <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            left_q   <= left_d;
            active_q <= active_d;
            write_q  <= write_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bus_bridge
//  Description : Host-driven bus initiator. Decodes 'W'/'R' frames from the
//                UART receive strobe, issues one 32-bit bus transaction and
//                returns the response through the UART transmit handshake.
//                Optional macro BRIDGE_TIMEOUT_EN aborts stalled frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_write,
    output logic [7:0]  tx_data,
    input  logic        tx_finished,
    output logic        bus_cs,
    output logic        bus_wren,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        wr_q,    wr_d;      // current frame is a write
    logic [1:0]  cnt_q,   cnt_d;     // byte index within the address/data field
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wait_q,  wait_d;    // cycles since the bus_cs cycle

    logic        ld;
    logic [31:0] ld_word;
    logic        ld_four;
    logic        tx_done;
    logic        timeout;

    // Bus select is the first BUS cycle only; wren never shows without cs
    assign bus_cs    = (state_q == BUS) && (wait_q == 8'd0);
    assign bus_wren  = bus_cs && wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

`ifdef BRIDGE_TIMEOUT_EN
    logic [31:0] to_q;
    logic        in_frame;
    assign in_frame = (state_q == ADDR) || (state_q == DATA);
    assign timeout  = in_frame && !rx_ready && (to_q == TIMEOUT_CYCLES - 1);

    // Inter-byte timer: runs only while collecting address/data bytes
    always_ff @(posedge clk) begin
        if (reset || !in_frame || rx_ready) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Frame decode, field shifting and response selection
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = 8'd0;
        ld      = 1'b0;
        ld_word = '0;
        ld_four = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    cnt_d = 2'd0;
                    if (rx_data == OP_WRITE) begin
                        wr_d    = 1'b1;
                        state_d = ADDR;
                    end else if (rx_data == OP_READ) begin
                        wr_d    = 1'b0;
                        state_d = ADDR;
                    end else begin
                        ld      = 1'b1;
                        ld_word = byte_word(RSP_ERR);
                        state_d = TX;
                    end
                end
            end
            ADDR: begin
                if (rx_ready) begin
                    addr_d = {rx_data, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'(FRAME_BYTES - 1)) begin
                        cnt_d   = 2'd0;
                        state_d = wr_q ? DATA : BUS;
                    end
                end else if (timeout) begin
                    ld      = 1'b1;
                    ld_word = byte_word(RSP_ERR);
                    state_d = TX;
                end
            end
            DATA: begin
                if (rx_ready) begin
                    wdata_d = {rx_data, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'(FRAME_BYTES - 1)) begin
                        cnt_d   = 2'd0;
                        state_d = BUS;
                    end
                end else if (timeout) begin
                    ld      = 1'b1;
                    ld_word = byte_word(RSP_ERR);
                    state_d = TX;
                end
            end
            BUS: begin
                wait_d = wait_q + 8'd1;
                if (wr_q && (wait_q == 8'd1)) begin
                    ld      = 1'b1;
                    ld_word = byte_word(RSP_ACK);
                    state_d = TX;
                end else if (!wr_q && (wait_q == 8'(READ_LATENCY))) begin
                    // Responder data is valid now; hand it straight to the sequencer
                    ld      = 1'b1;
                    ld_word = bus_rdata;
                    ld_four = 1'b1;
                    state_d = TX;
                end
            end
            TX: begin
                // Received bytes are ignored until the response is complete
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decoder registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
        end
    end

    uart_bridge_txseq u_txseq (
        .clk           (clk),
        .reset         (reset),
        .load_i        (ld),
        .word_i        (ld_word),
        .four_i        (ld_four),
        .tx_write_o    (tx_write),
        .tx_data_o     (tx_data),
        .tx_finished_i (tx_finished),
        .done_o        (tx_done)
    );

endmodule
`default_nettype wire
